// File: rtl/vec_feeder_if.sv
// ---------------------------------------------------------------------------
// vec_feeder_if -- bundle of every non-clock signal of the vector feeder.
//
//   Operand stream : in_valid, in_ready, in_x, in_k (one lane pair per beat)
//   Multiplier side: x, k (packed vectors, lane 0 in the LSBs), enable,
//                    y_in, y_valid
//   Result side    : res_valid, res_ready, res_data, res_err
//
//   modport slave  : the feeder itself
//   modport master : the environment (producer, multiplier, consumer)
// ---------------------------------------------------------------------------
interface vec_feeder_if #(
    parameter int C   = 16,
    parameter int W_X = 32,
    parameter int W_K = 32,
    parameter int W_Y = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W_X-1:0]       in_x;
    logic [W_K-1:0]       in_k;
    logic [C*W_X-1:0]     x;
    logic [C*W_K-1:0]     k;
    logic                 enable;
    logic [W_Y-1:0]       y_in;
    logic                 y_valid;
    logic                 res_valid;
    logic                 res_ready;
    logic [W_Y-1:0]       res_data;
    logic                 res_err;

    modport slave (
        input  in_valid, in_x, in_k, y_in, y_valid, res_ready,
        output in_ready, x, k, enable, res_valid, res_data, res_err
    );

    modport master (
        output in_valid, in_x, in_k, y_in, y_valid, res_ready,
        input  in_ready, x, k, enable, res_valid, res_data, res_err
    );
endinterface

// File: rtl/vec_feeder.sv
// ---------------------------------------------------------------------------
// vec_feeder -- collects C element-serial (x, k) operand pairs into packed
// lane vectors, enables an external dot-product multiplier, waits (bounded
// by TIMEOUT cycles) for its result and holds that result until consumed.
//
// Ports:
//   clk   : sole clock, rising edge
//   rstn  : asynchronous active-low reset
//   clr   : synchronous soft clear (returns to LOAD, lane contents kept)
//   bus   : vec_feeder_if.slave (operand stream, multiplier, result)
// ---------------------------------------------------------------------------
module vec_feeder #(
    parameter int C       = 16,
    parameter int W_X     = 32,
    parameter int W_K     = 32,
    parameter int W_Y     = 32,
    parameter int TIMEOUT = 4 * ($clog2(C) + 1)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    vec_feeder_if.slave bus
);
    localparam int IDX_W = (C > 1) ? $clog2(C) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_idx;
    logic [CNT_W-1:0]         r_wcnt;
    logic [C-1:0][W_X-1:0]    r_x;
    logic [C-1:0][W_K-1:0]    r_k;
    logic                     r_in_ready;
    logic                     r_enable;
    logic                     r_res_valid;
    logic [W_Y-1:0]           r_res_data;
    logic                     r_res_err;
    logic                     w_accept;
    logic                     w_capture;
    logic                     w_timeout;

    // Next-state decode; clr overrides every transition and every side effect
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        if (clr) begin
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    w_accept = bus.in_valid;
                    if (bus.in_valid && (r_idx == IDX_LAST)) begin
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
                S_ISSUE: begin
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving in the last allowed cycle still wins
                    if (bus.y_valid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else if (r_wcnt == CNT_LAST) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
                default: begin
                    w_state_nxt = S_LOAD;
                end
            endcase
        end
    end

    // State register plus handshake/enable flags registered from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_LOAD;
            r_in_ready  <= 1'b1;
            r_enable    <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_LOAD);
            r_enable    <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);
            r_res_valid <= (w_state_nxt == S_HOLD);
        end
    end

    // Lane index and wait counter; the counter restarts at 0 on every WAIT entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx  <= {IDX_W{1'b0}};
            r_wcnt <= {CNT_W{1'b0}};
        end else begin
            if (clr) begin
                r_idx <= {IDX_W{1'b0}};
            end else if (w_accept) begin
                r_idx <= (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
            end
            if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
                r_wcnt <= r_wcnt + CNT_W'(1);
            end else begin
                r_wcnt <= {CNT_W{1'b0}};
            end
        end
    end

    // Lane storage: only an accepted pair writes, so clr leaves contents intact
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x <= {(C*W_X){1'b0}};
            r_k <= {(C*W_K){1'b0}};
        end else if (w_accept) begin
            r_x[r_idx] <= bus.in_x;
            r_k[r_idx] <= bus.in_k;
        end
    end

    // Result capture: a multiplier result or a zero/error result on timeout
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res_data <= {W_Y{1'b0}};
            r_res_err  <= 1'b0;
        end else if (clr) begin
            r_res_err  <= 1'b0;
        end else if (w_capture) begin
            r_res_data <= bus.y_in;
            r_res_err  <= 1'b0;
        end else if (w_timeout) begin
            r_res_data <= {W_Y{1'b0}};
            r_res_err  <= 1'b1;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.x         = r_x;
    assign bus.k         = r_k;
    assign bus.enable    = r_enable;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_err   = r_res_err;
endmodule

// File: tb/tb_vec_feeder.sv
// ---------------------------------------------------------------------------
// tb_vec_feeder -- directed + randomized self-checking bench for vec_feeder.
// A behavioural multiplier returns sum(x[i]*k[i]) L cycles after enable
// rises; expected lanes and results come from the bench's own lane array.
// ---------------------------------------------------------------------------
module tb_vec_feeder;
    localparam int C  = 16;
    localparam int W  = 32;
    localparam int L  = 5;
    localparam int TO = 20;
    localparam int VW = C * W;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic clr  = 1'b0;

    vec_feeder_if #(.C(C), .W_X(W), .W_K(W), .W_Y(W)) bus ();

    vec_feeder #(.C(C), .W_X(W), .W_K(W), .W_Y(W), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int           n_chk = 0;
    int           n_err = 0;
    int           ref_x [C];
    int           ref_k [C];
    int           ref_idx;
    logic [W-1:0] jx [C];
    logic [W-1:0] jk [C];
    bit           mul_on;
    int           m_cnt;
    logic         m_en_q;
    logic [W-1:0] m_res;
    int           c;
    logic [W-1:0] exp_res;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] ref_vec(input bit is_k);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < C; i++) v[i*W +: W] = is_k ? ref_k[i] : ref_x[i];
        return v;
    endfunction

    function automatic logic [W-1:0] ref_dot();
        longint acc;
        acc = 0;
        for (int i = 0; i < C; i++) acc += longint'(ref_x[i]) * longint'(ref_k[i]);
        return acc[W-1:0];
    endfunction

    function automatic logic [W-1:0] mul_dot(input logic [VW-1:0] xv, input logic [VW-1:0] kv);
        longint acc;
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        acc = 0;
        for (int i = 0; i < C; i++) begin
            a = xv[i*W +: W];
            b = kv[i*W +: W];
            acc += longint'(a) * longint'(b);
        end
        return acc[W-1:0];
    endfunction

    // Behavioural multiplier: result valid L cycles after enable rises
    always @(negedge clk) begin
        if (!rstn) begin
            m_cnt       <= 0;
            m_en_q      <= 1'b0;
            bus.y_valid <= 1'b0;
            bus.y_in    <= '0;
        end else begin
            m_en_q <= bus.enable;
            if (bus.enable && !m_en_q && mul_on) begin
                m_cnt       <= L;
                m_res       <= mul_dot(bus.x, bus.k);
                bus.y_valid <= 1'b0;
            end else if (m_cnt == 1) begin
                m_cnt       <= 0;
                bus.y_valid <= 1'b1;
                bus.y_in    <= m_res;
            end else begin
                if (m_cnt != 0) m_cnt <= m_cnt - 1;
                bus.y_valid <= 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < C; i++) begin
            ref_x[i] = 0;
            ref_k[i] = 0;
        end
        ref_idx = 0;
    endtask

    task automatic rand_job();
        for (int i = 0; i < C; i++) begin
            jx[i] = $urandom;
            jk[i] = $urandom;
        end
    endtask

    task automatic send_pair(input logic [W-1:0] xv, input logic [W-1:0] kv);
        int t;
        bus.in_valid = 1'b1;
        bus.in_x     = xv;
        bus.in_k     = kv;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            cyc();
            t++;
        end
        chk("in_ready_wait", bus.in_ready, 1'b1);
        cyc();
        bus.in_valid   = 1'b0;
        ref_x[ref_idx] = xv;
        ref_k[ref_idx] = kv;
        ref_idx        = (ref_idx + 1) % C;
    endtask

    task automatic load_lanes(input int first, input int n, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) cyc();
            if (ref_idx == C - 1) chk("enable_pre_last", bus.enable, 1'b0);
            send_pair(jx[i], jk[i]);
        end
    endtask

    task automatic after_full_load();
        chk("enable_after_last", bus.enable, 1'b1);
        chk("in_ready_issue", bus.in_ready, 1'b0);
    endtask

    task automatic wait_hold(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (bus.res_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic chk_result(input logic [W-1:0] d, input logic e);
        chk("res_valid", bus.res_valid, 1'b1);
        chk("res_data", bus.res_data, d);
        chk("res_err", bus.res_err, e);
        chk("x_vec", bus.x, ref_vec(1'b0));
        chk("k_vec", bus.k, ref_vec(1'b1));
        chk("enable_hold", bus.enable, 1'b0);
    endtask

    task automatic release_res();
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
        chk("in_ready_release", bus.in_ready, 1'b1);
        chk("res_valid_release", bus.res_valid, 1'b0);
    endtask

    task automatic do_job(input bit gaps);
        load_lanes(0, C, gaps);
        after_full_load();
        wait_hold(c);
        chk("latency", c, 32'd6);
        chk_result(ref_dot(), 1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_k      = '0;
        bus.res_ready = 1'b0;
        mul_on        = 1'b1;
        clear_ref();

        // Reset values
        repeat (2) cyc();
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_enable", bus.enable, 1'b0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_res_err", bus.res_err, 1'b0);
        chk("rst_x", bus.x, ref_vec(1'b0));
        chk("rst_k", bus.k, ref_vec(1'b1));
        @(negedge clk);
        rstn = 1'b1;
        cyc();

        // Basic job: x=i+1, k=2 -> 272
        for (int i = 0; i < C; i++) begin
            jx[i] = W'(i + 1);
            jk[i] = 32'd2;
        end
        do_job(1'b0);
        chk("basic_272", bus.res_data, 32'd272);
        release_res();

        // Signed job: -3 * 7 over 16 lanes -> -336
        for (int i = 0; i < C; i++) begin
            jx[i] = 32'hFFFF_FFFD;
            jk[i] = 32'd7;
        end
        do_job(1'b0);
        chk("signed_m336", bus.res_data, 32'hFFFF_FEB0);
        release_res();

        // Backpressure with in_valid driven junk during HOLD
        rand_job();
        do_job(1'b0);
        exp_res = ref_dot();
        bus.in_valid = 1'b1;
        bus.in_x     = $urandom;
        bus.in_k     = $urandom;
        repeat (10) begin
            cyc();
            chk("bp_res_valid", bus.res_valid, 1'b1);
            chk("bp_res_data", bus.res_data, exp_res);
            chk("bp_res_err", bus.res_err, 1'b0);
            chk("bp_in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
        chk("bp_x_kept", bus.x, ref_vec(1'b0));
        chk("bp_k_kept", bus.k, ref_vec(1'b1));
        release_res();

        // Random idle gaps between pairs
        repeat (2) begin
            rand_job();
            do_job(1'b1);
            release_res();
        end

        // Timeout: multiplier silent, HOLD 20 cycles after WAIT entry
        mul_on = 1'b0;
        rand_job();
        load_lanes(0, C, 1'b0);
        after_full_load();
        wait_hold(c);
        chk("timeout_cycles", c, 32'd21);
        chk_result(32'd0, 1'b1);
        release_res();
        mul_on = 1'b1;

        // clr coinciding with y_valid in WAIT: result discarded, res_err cleared
        rand_job();
        load_lanes(0, C, 1'b0);
        after_full_load();
        repeat (5) cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clrw_enable", bus.enable, 1'b0);
        chk("clrw_res_valid", bus.res_valid, 1'b0);
        chk("clrw_in_ready", bus.in_ready, 1'b1);
        chk("clrw_res_err", bus.res_err, 1'b0);
        repeat (3) cyc();
        chk("clrw_res_valid_late", bus.res_valid, 1'b0);

        // clr early in WAIT: the late y_valid lands in LOAD and is ignored
        rand_job();
        load_lanes(0, C, 1'b0);
        after_full_load();
        repeat (2) cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clre_enable", bus.enable, 1'b0);
        repeat (6) cyc();
        chk("clre_res_valid", bus.res_valid, 1'b0);
        chk("clre_in_ready", bus.in_ready, 1'b1);
        chk("clre_x_kept", bus.x, ref_vec(1'b0));
        chk("clre_k_kept", bus.k, ref_vec(1'b1));
        rand_job();
        do_job(1'b0);
        release_res();

        // clr after 7 accepts: contents kept, next pair lands in lane 0
        rand_job();
        load_lanes(0, 7, 1'b0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        ref_idx = 0;
        chk("clr7_in_ready", bus.in_ready, 1'b1);
        chk("clr7_x_kept", bus.x, ref_vec(1'b0));
        chk("clr7_k_kept", bus.k, ref_vec(1'b1));
        rand_job();
        load_lanes(0, 1, 1'b0);
        chk("clr7_lane0_x", bus.x, ref_vec(1'b0));
        chk("clr7_lane0_k", bus.k, ref_vec(1'b1));
        load_lanes(1, C - 1, 1'b1);
        after_full_load();
        wait_hold(c);
        chk("clr7_latency", c, 32'd6);
        chk_result(ref_dot(), 1'b0);
        release_res();

        // Asynchronous reset pulsed mid-WAIT
        rand_job();
        load_lanes(0, C, 1'b0);
        after_full_load();
        repeat (2) cyc();
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        clear_ref();
        chk("arst_in_ready", bus.in_ready, 1'b1);
        chk("arst_enable", bus.enable, 1'b0);
        chk("arst_res_valid", bus.res_valid, 1'b0);
        chk("arst_res_data", bus.res_data, 32'd0);
        chk("arst_res_err", bus.res_err, 1'b0);
        chk("arst_x", bus.x, ref_vec(1'b0));
        chk("arst_k", bus.k, ref_vec(1'b1));
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cyc();
        repeat (8) cyc();
        chk("arst_no_residual", bus.res_valid, 1'b0);
        for (int i = 0; i < C; i++) begin
            jx[i] = W'(i + 1);
            jk[i] = 32'd2;
        end
        do_job(1'b0);
        chk("post_rst_272", bus.res_data, 32'd272);
        release_res();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vec_feeder.md
VEC_FEEDER -- requirements
Module: vec_feeder

Interface
REQ-001 Parameter C, default 16, number of lanes per operand vector.
REQ-002 Parameter W_X, default 32, width of one x element.
REQ-003 Parameter W_K, default 32, width of one k element.
REQ-004 Parameter W_Y, default 32, width of the dot-product result.
REQ-005 Parameter TIMEOUT, default 4*($clog2(C)+1), maximum WAIT cycles before the job aborts.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rstn  input  1  asynchronous, active-low reset.
REQ-008 clr  input  1  synchronous soft clear.
REQ-009 in_valid  input  1  element-serial operand pair valid.
REQ-010 in_ready  output  1  feeder accepts an operand pair.
REQ-011 in_x  input  W_X  signed x element.
REQ-012 in_k  input  W_K  signed k element.
REQ-013 x  output  C x W_X  packed x vector to the multiplier; lane 0 in the LSBs.
REQ-014 k  output  C x W_K  packed k vector to the multiplier; lane 0 in the LSBs.
REQ-015 enable  output  1  multiplier enable.
REQ-016 y_in  input  W_Y  signed result from the multiplier.
REQ-017 y_valid  input  1  y_in valid.
REQ-018 res_valid  output  1  result available.
REQ-019 res_ready  input  1  consumer accepts the result.
REQ-020 res_data  output  W_Y  captured signed result.
REQ-021 res_err  output  1  result aborted by timeout.

Function
REQ-022 The FSM SHALL have the states LOAD, ISSUE, WAIT and HOLD, and SHALL enter LOAD on reset.
REQ-023 LOAD behaviour:
- in_ready=1.
- Each in_valid&&in_ready cycle writes in_x/in_k into lane idx and then increments idx.
- idx runs 0..C-1.
- Accepting the pair at idx==C-1 SHALL move the FSM to ISSUE and clear idx to 0.
REQ-024 in_ready SHALL be 0 in ISSUE, WAIT and HOLD, and in those states in_valid SHALL be ignored.
REQ-025 ISSUE SHALL last exactly one cycle, with enable=1, then move to WAIT with the wait counter at 0.
REQ-026 enable SHALL stay 1 throughout WAIT and SHALL be 0 in LOAD and HOLD.
REQ-027 x and k SHALL hold their values from the last lane write until the next LOAD write to the same lane.
REQ-028 WAIT behaviour:
- The first cycle with y_valid=1 captures y_in into res_data, clears res_err and moves to HOLD.
- Otherwise the wait counter increments.
REQ-029 If the wait counter reaches TIMEOUT-1 without y_valid, the next edge SHALL move to HOLD with res_data=0 and res_err=1.
REQ-030 y_valid SHALL be ignored outside WAIT.
REQ-031 HOLD behaviour:
- res_valid=1.
- res_data and res_err are stable.
- res_valid&&res_ready moves to LOAD, so in_ready=1 on the following cycle.
REQ-032 res_data SHALL be a bit-exact pass-through of y_in, with no sign extension or truncation beyond W_Y.
REQ-033 clr=1 SHALL have priority over all transitions and, at the next edge, SHALL:
- force LOAD;
- set idx=0, enable=0, res_valid=0 and res_err=0;
- leave the x and k contents unchanged.
REQ-034 If clr and y_valid coincide in WAIT, clr SHALL win and the result SHALL be discarded.
REQ-035 Throughput SHALL be C+2+L+1 cycles minimum per job, where L is the multiplier latency, given back-to-back in_valid and res_ready=1.

Reset
REQ-036 When rstn=0, the block SHALL immediately force:
- state LOAD and idx=0;
- x=0, k=0, enable=0;
- res_valid=0, res_data=0, res_err=0;
- in_ready=1 (driven from the LOAD state, including while rstn=0).
REQ-037 Reset assertion in any state, including mid-WAIT, SHALL abandon the job with no residual output.

Verification
REQ-038 The bench SHALL use a behavioural multiplier model that returns sum(x[i]*k[i]) with y_valid L=5 cycles after enable rises; C=16 and TIMEOUT=20.
REQ-039 Basic job: reset, then 16 back-to-back pairs x[i]=i+1, k[i]=2 -> enable rises the cycle after the 16th accept; res_valid with res_data=272 and res_err=0.
REQ-040 Signed job: x[i]=-3, k[i]=7 for all lanes -> res_data=-336 (two's complement, W_Y bits).
REQ-041 Backpressure: res_ready held 0 for 10 cycles in HOLD -> res_valid, res_data and res_err stable, in_ready=0; on res_ready=1, in_ready=1 the next cycle.
REQ-042 Input gaps: random idle cycles between pairs -> lanes filled in acceptance order, and exactly 16 accepts precede enable.
REQ-043 Timeout: model never asserts y_valid -> HOLD entered exactly 20 cycles after entering WAIT, with res_err=1 and res_data=0.
REQ-044 clr and reset:
- clr after 7 accepts -> the next job's first pair lands in lane 0.
- clr in WAIT -> enable=0, and a late y_valid is ignored.
- rstn pulsed low mid-WAIT -> all outputs at reset values asynchronously.
